// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch stage: FSM state encoding and the IF/ID record.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        valid;
    } ifid_t;

    // Builds the IF/ID contents for a squashed or reset slot.
    function automatic ifid_t ifid_nop(input logic [31:0] nop_instr);
        ifid_t r;
        r.instr = nop_instr;
        r.pc    = '0;
        r.npc   = '0;
        r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch unit, program counter, imem and decode.
interface fetch_unit_if;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        flush;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        pc_en;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_npc;

    modport fu (
        input  pc, npc, ihit, iload, stall, flush, halt,
        output imemREN, imemaddr, pc_en,
               ifid_valid, ifid_instr, ifid_pc, ifid_npc
    );

    modport tb (
        output pc, npc, ihit, iload, stall, flush, halt,
        input  imemREN, imemaddr, pc_en,
               ifid_valid, ifid_instr, ifid_pc, ifid_npc
    );
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Priority: reset/flush > load > bubble > hold.
module ifid_reg
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic  clk_i,
    input  logic  nrst_i,
    input  logic  load_i,
    input  logic  flush_i,
    input  logic  bubble_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t q_q;

    // Squash to NOP on reset/flush, capture on load, drop valid on a bubble.
    always_ff @(posedge clk_i) begin
        if (!nrst_i || flush_i) begin
            q_q <= ifid_nop(NOP_INSTR);
        end else if (load_i) begin
            q_q <= d_i;
        end else if (bubble_i) begin
            q_q.valid <= 1'b0;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives imem and PC enable, skid-buffers a hit that
// lands during a decode stall, and handles flush/halt.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic     CLK,
    input  logic     nRST,
    fetch_unit_if.fu fuif
);

    fetch_state_t state_q, state_d;
    ifid_t        skid_q, skid_d;
    ifid_t        ifid_d, ifid_q;
    logic         ifid_load, ifid_flush, ifid_bubble;
    logic         ren, pcen;
    ifid_t        hit_word;

    assign hit_word = '{instr: fuif.iload, pc: fuif.pc, npc: fuif.npc, valid: 1'b1};

    // State and skid buffer registers; reset drops any transfer in flight.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= FETCH;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            skid_q  <= skid_d;
        end
    end

    // Next state, memory/PC controls and IF/ID commands.
    // halt beats flush, flush beats stall and ihit; HALTED only leaves via reset.
    always_comb begin
        state_d     = state_q;
        skid_d      = skid_q;
        ifid_d      = hit_word;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        ifid_bubble = 1'b0;
        ren         = 1'b0;
        pcen        = 1'b0;
        if (fuif.halt) begin
            state_d = HALTED;
        end else if (state_q == HALTED) begin
            state_d = HALTED;
        end else if (fuif.flush) begin
            ren        = (state_q == FETCH);
            pcen       = 1'b1;
            ifid_flush = 1'b1;
            skid_d     = '0;
            state_d    = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    ren = 1'b1;
                    if (fuif.ihit && !fuif.stall) begin
                        ifid_load = 1'b1;
                        pcen      = 1'b1;
                    end else if (fuif.ihit) begin
                        skid_d  = hit_word;
                        pcen    = 1'b1;
                        state_d = HOLD;
                    end else if (!fuif.stall) begin
                        ifid_bubble = 1'b1;
                    end
                end
                HOLD: begin
                    if (!fuif.stall) begin
                        ifid_d       = skid_q;
                        ifid_d.valid = 1'b1;
                        ifid_load    = 1'b1;
                        state_d      = FETCH;
                    end
                end
                default: state_d = HALTED;
            endcase
        end
    end

    ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
        .clk_i    (CLK),
        .nrst_i   (nRST),
        .load_i   (ifid_load),
        .flush_i  (ifid_flush),
        .bubble_i (ifid_bubble),
        .d_i      (ifid_d),
        .q_o      (ifid_q)
    );

    // Requests are held off combinationally while reset is asserted.
    assign fuif.imemREN    = ren & nRST;
    assign fuif.pc_en      = pcen & nRST;
    assign fuif.imemaddr   = fuif.pc;
    assign fuif.ifid_valid = ifid_q.valid;
    assign fuif.ifid_instr = ifid_q.instr;
    assign fuif.ifid_pc    = ifid_q.pc;
    assign fuif.ifid_npc   = ifid_q.npc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic CLK = 1'b0;
    logic nRST;
    int   vectors = 0;
    int   miscompares = 0;

    fetch_unit_if fuif();

    fetch_unit #(.NOP_INSTR(NOP)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .fuif (fuif)
    );

    always #5 CLK = ~CLK;

    // Reference model: what decode currently sees, accepted-but-undelivered
    // instructions, and whether fetching has been halted.
    logic [31:0] m_instr = NOP, m_pc = '0, m_npc = '0;
    logic        m_valid = 1'b0;
    logic        m_halted = 1'b0;
    ifid_t       pend[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ren();
        return nRST && !fuif.halt && !m_halted && (pend.size() == 0);
    endfunction

    function automatic logic exp_pcen();
        return nRST && !fuif.halt && !m_halted &&
               (fuif.flush || (pend.size() == 0 && fuif.ihit));
    endfunction

    always @(posedge CLK) begin
        ifid_t w;
        if (!nRST) begin
            m_instr = NOP; m_pc = '0; m_npc = '0; m_valid = 1'b0;
            m_halted = 1'b0; pend.delete();
        end else if (fuif.halt) begin
            m_halted = 1'b1;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (fuif.flush) begin
            m_instr = NOP; m_pc = '0; m_npc = '0; m_valid = 1'b0;
            pend.delete();
        end else if (pend.size() > 0) begin
            if (!fuif.stall) begin
                w = pend.pop_front();
                m_instr = w.instr; m_pc = w.pc; m_npc = w.npc; m_valid = 1'b1;
            end
        end else if (fuif.ihit) begin
            if (fuif.stall) begin
                w = '{instr: fuif.iload, pc: fuif.pc, npc: fuif.npc, valid: 1'b1};
                pend.push_back(w);
            end else begin
                m_instr = fuif.iload; m_pc = fuif.pc; m_npc = fuif.npc; m_valid = 1'b1;
            end
        end else if (!fuif.stall) begin
            m_valid = 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        chk("imemREN", {31'b0, fuif.imemREN}, {31'b0, exp_ren()});
        chk("imemaddr", fuif.imemaddr, fuif.pc);
        chk("pc_en", {31'b0, fuif.pc_en}, {31'b0, exp_pcen()});
        chk("ifid_valid", {31'b0, fuif.ifid_valid}, {31'b0, m_valid});
        chk("ifid_instr", fuif.ifid_instr, m_instr);
        chk("ifid_pc", fuif.ifid_pc, m_pc);
        chk("ifid_npc", fuif.ifid_npc, m_npc);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic h, input logic [31:0] p, input logic [31:0] ld,
                         input logic s, input logic f, input logic hl);
        fuif.ihit = h; fuif.pc = p; fuif.npc = p + 32'd4; fuif.iload = ld;
        fuif.stall = s; fuif.flush = f; fuif.halt = hl;
    endtask

    initial begin
        logic [31:0] rpc;
        logic        adv, redir;
        nRST = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset
        step(); step();
        fuif.ihit = 1'b1;
        settle();
        chk("rst imemREN", {31'b0, fuif.imemREN}, 32'd0);
        chk("rst pc_en", {31'b0, fuif.pc_en}, 32'd0);
        chk("rst ifid_valid", {31'b0, fuif.ifid_valid}, 32'd0);
        chk("rst ifid_instr", fuif.ifid_instr, 32'd0);
        nRST = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("rel imemREN", {31'b0, fuif.imemREN}, 32'd1);
        chk("rel imemaddr", fuif.imemaddr, 32'h0);

        // Streaming
        drive(1'b1, 32'h0, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0); settle();
        chk("stream pc_en", {31'b0, fuif.pc_en}, 32'd1);
        step();
        chk("stream instr A", fuif.ifid_instr, 32'hAAAA_0001);
        chk("stream pc A", fuif.ifid_pc, 32'h0);
        drive(1'b1, 32'h4, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0); settle();
        chk("stream pc_en B", {31'b0, fuif.pc_en}, 32'd1);
        step();
        chk("stream instr B", fuif.ifid_instr, 32'hBBBB_0002);
        chk("stream pc B", fuif.ifid_pc, 32'h4);
        drive(1'b1, 32'h8, 32'hCCCC_0003, 1'b0, 1'b0, 1'b0); step();
        chk("stream instr C", fuif.ifid_instr, 32'hCCCC_0003);
        chk("stream npc C", fuif.ifid_npc, 32'hC);

        // Memory wait
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0); settle();
            chk("wait pc_en", {31'b0, fuif.pc_en}, 32'd0);
            step();
            chk("wait ifid_valid", {31'b0, fuif.ifid_valid}, 32'd0);
        end
        drive(1'b1, 32'h10, 32'h8C01_0000, 1'b0, 1'b0, 1'b0); step();
        chk("wait instr", fuif.ifid_instr, 32'h8C01_0000);
        chk("wait pc", fuif.ifid_pc, 32'h10);
        chk("wait valid", {31'b0, fuif.ifid_valid}, 32'd1);

        // Stall with hit -> HOLD
        drive(1'b1, 32'h24, 32'h2002_0005, 1'b1, 1'b0, 1'b0); step();
        drive(1'b0, 32'h28, 32'h0, 1'b1, 1'b0, 1'b0); settle();
        chk("hold imemREN", {31'b0, fuif.imemREN}, 32'd0);
        chk("hold frozen", fuif.ifid_instr, 32'h8C01_0000);
        step();
        drive(1'b0, 32'h28, 32'h0, 1'b0, 1'b0, 1'b0); settle();
        chk("release imemREN", {31'b0, fuif.imemREN}, 32'd0);
        chk("release pc_en", {31'b0, fuif.pc_en}, 32'd0);
        step();
        chk("release instr", fuif.ifid_instr, 32'h2002_0005);
        chk("release npc", fuif.ifid_npc, 32'h28);
        chk("release valid", {31'b0, fuif.ifid_valid}, 32'd1);
        settle();
        chk("refetch imemREN", {31'b0, fuif.imemREN}, 32'd1);

        // Flush over stall+ihit while in HOLD
        drive(1'b1, 32'h28, 32'h1234_5678, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 32'h2C, 32'h5555_5555, 1'b1, 1'b1, 1'b0); settle();
        chk("flush pc_en", {31'b0, fuif.pc_en}, 32'd1);
        step();
        chk("flush valid", {31'b0, fuif.ifid_valid}, 32'd0);
        chk("flush instr", fuif.ifid_instr, NOP);
        drive(1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0); settle();
        chk("flush redirect ren", {31'b0, fuif.imemREN}, 32'd1);
        chk("flush redirect addr", fuif.imemaddr, 32'h100);
        step();
        chk("flush buffer dropped", {31'b0, fuif.ifid_valid}, 32'd0);

        // Randomized traffic; PC follows the expected enable and flush targets.
        rpc = 32'h100;
        for (int i = 0; i < 3000; i++) begin
            nRST = ($urandom_range(0, 99) >= 2);
            drive($urandom_range(0, 99) < 70, rpc, $urandom,
                  $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8, 1'b0);
            #2;
            adv   = exp_pcen();
            redir = fuif.flush;
            step();
            if (!nRST) rpc = 32'h0;
            else if (adv && redir) rpc = {$urandom_range(0, 32'h3FFF), 2'b00};
            else if (adv) rpc = rpc + 32'd4;
        end

        // Halt beats flush; only reset recovers.
        nRST = 1'b0; step();
        nRST = 1'b1;
        drive(1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0); step();
        chk("pre-halt instr", fuif.ifid_instr, 32'hDEAD_BEEF);
        drive(1'b1, 32'h204, 32'h1111_1111, 1'b0, 1'b1, 1'b1); settle();
        chk("halt pc_en", {31'b0, fuif.pc_en}, 32'd0);
        chk("halt imemREN", {31'b0, fuif.imemREN}, 32'd0);
        step();
        for (int i = 0; i < 10; i++) begin
            drive($urandom_range(0, 1), 32'h204, $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 1), 1'b0);
            settle();
            chk("halted imemREN", {31'b0, fuif.imemREN}, 32'd0);
            chk("halted pc_en", {31'b0, fuif.pc_en}, 32'd0);
            chk("halted instr", fuif.ifid_instr, 32'hDEAD_BEEF);
            chk("halted pc", fuif.ifid_pc, 32'h200);
            step();
        end
        nRST = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); step();
        chk("post-halt rst valid", {31'b0, fuif.ifid_valid}, 32'd0);
        nRST = 1'b1; settle();
        chk("post-halt imemREN", {31'b0, fuif.imemREN}, 32'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly downstream of `program_counter`. Each cycle it presents the current PC to instruction memory, waits for `ihit`, and captures the returned instruction plus its PC/PC+4 into the IF/ID pipeline register. It drives the program counter's enable, so the PC advances only when an instruction has actually been accepted. It also absorbs decode-side stalls, branch/jump flushes and halt.

## Interface
Parameters:
- `NOP_INSTR`, default 32'h0000_0000: instruction word written into IF/ID on flush/reset.

Ports (signals other than `CLK` and `nRST` are carried by `fetch_unit_if`, modport `fu`):
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  reset, synchronous, active-low.
- `pc`  in  32  current PC from `program_counter`.
- `npc`  in  32  PC+4 from `program_counter`.
- `ihit`  in  1  instruction memory returns valid data this cycle.
- `iload`  in  32  instruction word, valid when `ihit`.
- `stall`  in  1  hazard unit: IF/ID must hold.
- `flush`  in  1  taken branch/jump resolved: squash fetched work; PC mux is selecting the target.
- `halt`  in  1  halt seen downstream: stop fetching.
- `imemREN`  out  1  instruction read enable.
- `imemaddr`  out  32  instruction read address.
- `pc_en`  out  1  to `program_counter` `PCEN`.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `ifid_instr`  out  32  latched instruction.
- `ifid_pc`  out  32  PC of the latched instruction.
- `ifid_npc`  out  32  PC+4 of the latched instruction.

## Operation
- FSM states: FETCH, HOLD, HALTED. Reset state is FETCH.
- FETCH:
  - `imemREN`=1 and `imemaddr`=`pc`.
  - `ihit & ~stall`: load IF/ID with {`iload`,`pc`,`npc`}, set `ifid_valid`=1, `pc_en`=1, stay in FETCH.
  - `ihit & stall`: copy {`iload`,`pc`,`npc`} into the skid buffer, `pc_en`=1, go to HOLD.
  - `~ihit`: `pc_en`=0 and IF/ID is unchanged, except that `ifid_valid`←0 when `~stall`, which inserts a bubble.
- HOLD:
  - `imemREN`=0 and `pc_en`=0. `imemaddr`=`pc`, ignored by memory.
  - When `~stall`: move the buffer into IF/ID, set `ifid_valid`=1, go to FETCH.
- HALTED:
  - `imemREN`=0, `pc_en`=0, IF/ID frozen.
  - Exits only through reset.
- `flush`:
  - Overrides `stall` and `ihit`.
  - `pc_en`=1 so the redirected `new_pc` is loaded.
  - IF/ID becomes {`NOP_INSTR`,0,0} with `ifid_valid`=0.
  - The skid buffer is discarded and the state goes to FETCH.
  - Any same-cycle `ihit` data is dropped.
- `halt`:
  - Highest priority, including over `flush`.
  - Goes to HALTED, `pc_en`=0, IF/ID unchanged.
- Arithmetic: none. `npc` is passed through unmodified; 32-bit wrap of PC is the program counter's concern.

## Timing
- While `nRST`=0: `imemREN`=0 and `pc_en`=0, gated combinationally by `nRST`.
- On the `CLK` edge with `nRST`=0:
  - state←FETCH.
  - `ifid_valid`←0, `ifid_instr`←`NOP_INSTR`, `ifid_pc`←0, `ifid_npc`←0.
  - Skid buffer cleared.
- Reset overrides everything, including a transfer in flight. First request is the cycle after `nRST` rises.
- `imemREN`, `imemaddr` and `pc_en` are combinational from state and inputs. IF/ID outputs are registered.
- Latency: `ihit` in cycle N gives the instruction on `ifid_*` in cycle N+1.
- Throughput: with `ihit` every cycle and no stall, one instruction per cycle.
- `pc_en` is asserted at most once per accepted instruction. The PC never advances without an `ihit` or `flush`.
- HOLD→FETCH costs one cycle with no memory request; the next fetch issues the cycle after the release.

## Structure
- `fetch_state_t` (FETCH/HOLD/HALTED) and `ifid_t` (instr, pc, npc, valid) belong in `cpu_types_pkg`.
- Signal bundle goes in `fetch_unit_if.vh`, with modports `fu` and `tb`.
- One sub-module: `ifid_reg`, the IF/ID pipeline register with load/flush/hold controls and synchronous active-low reset.
- The FSM and skid buffer stay in `fetch_unit`.

## Test plan
- Reset: hold `nRST`=0 for 2 cycles → `imemREN`=0, `pc_en`=0, `ifid_valid`=0, `ifid_instr`=0. Release → `imemREN`=1, `imemaddr`=`pc`.
- Streaming: `ihit`=1 every cycle, `pc` 0,4,8 with `iload` A,B,C → `ifid_instr` A,B,C on the following cycles, `ifid_pc` 0,4,8, `pc_en`=1 each cycle.
- Memory wait: `ihit` low 3 cycles at `pc`=0x10, then high with 0x8C010000 → `pc_en`=0 for 3 cycles, `ifid_valid`=0, then `ifid_instr`=0x8C010000, `ifid_pc`=0x10.
- Stall with hit: `stall`=1 when `ihit` returns 0x20020005 at `pc`=0x24 → HOLD with `imemREN`=0. Release `stall` → `ifid_instr`=0x20020005, `ifid_npc`=0x28, back to FETCH.
- Flush priority: `flush`=1 with `stall`=1, `ihit`=1, state HOLD → `pc_en`=1, `ifid_valid`=0, `ifid_instr`=NOP, buffer dropped, next request at the new `pc`.
- Halt: `halt`=1 together with `flush`=1 → `pc_en`=0, `imemREN`=0 forever, IF/ID frozen. Recovery only through `nRST`.
